// File: rtl/alu_writeback_regfile.sv
// ---------------------------------------------------------------------------
// alu_writeback_regfile
//
// Integer register file that feeds the ALU operands and absorbs its result.
// An ALU result is first captured into a one-entry writeback register and is
// committed to the register array on the following edge. Until it commits,
// the read ports see it through a bypass, so dependent back-to-back ALU ops
// read fresh data.
//
// Ports:
//   clk                in   system clock, rising edge
//   reset              in   synchronous, active-high reset
//   Reg_Write_i        in   current ALU result is to be written back
//   Write_Register_i   in   destination index for the current ALU result
//   ALU_Result_i       in   ALU result data
//   Zero_i             in   ALU zero flag
//   Stall_i            in   freeze the writeback stage (capture and commit)
//   Flush_i            in   capture the current ALU result as invalid
//   Read_Register_1_i  in   read index, port 1 (ALU A operand)
//   Read_Register_2_i  in   read index, port 2 (ALU B operand)
//   Read_Data_1_o      out  port 1 data, combinational
//   Read_Data_2_o      out  port 2 data, combinational
//   Wb_Valid_o         out  writeback register holds a pending write
//   Wb_Register_o      out  pending destination index
//   Zero_q_o           out  registered zero flag of the last captured result
// ---------------------------------------------------------------------------
module alu_writeback_regfile #(
  parameter int                DATA_WIDTH = 32,
  parameter int                ADDR_WIDTH = 5,
  parameter logic [DATA_WIDTH-1:0] SP_INIT = 32'h7FFF_EFFC,
  parameter logic [DATA_WIDTH-1:0] GP_INIT = 32'h1000_8000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  Reg_Write_i,
  input  logic [ADDR_WIDTH-1:0] Write_Register_i,
  input  logic [DATA_WIDTH-1:0] ALU_Result_i,
  input  logic                  Zero_i,
  input  logic                  Stall_i,
  input  logic                  Flush_i,
  input  logic [ADDR_WIDTH-1:0] Read_Register_1_i,
  input  logic [ADDR_WIDTH-1:0] Read_Register_2_i,
  output logic [DATA_WIDTH-1:0] Read_Data_1_o,
  output logic [DATA_WIDTH-1:0] Read_Data_2_o,
  output logic                  Wb_Valid_o,
  output logic [ADDR_WIDTH-1:0] Wb_Register_o,
  output logic                  Zero_q_o
);

  localparam int NUM_REGS = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];
  logic [DATA_WIDTH-1:0] wb_data;
  logic                  commit_en;

  // x0 is never written, so a pending write to it is simply dropped at commit.
  assign commit_en = Wb_Valid_o && !Stall_i && (Wb_Register_o != '0);

  // Register array: reset loads the ABI stack/global pointers into x2/x3.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
      regs[2] <= SP_INIT;
      regs[3] <= GP_INIT;
    end else if (commit_en) begin
      regs[Wb_Register_o] <= wb_data;
    end
  end

  // Writeback register: holds completely while stalled, so a flush seen
  // during a stall has no effect until the first unstalled edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      Wb_Valid_o    <= 1'b0;
      Wb_Register_o <= '0;
      wb_data       <= '0;
      Zero_q_o      <= 1'b0;
    end else if (!Stall_i) begin
      Wb_Valid_o    <= Reg_Write_i & ~Flush_i;
      Wb_Register_o <= Write_Register_i;
      wb_data       <= ALU_Result_i;
      Zero_q_o      <= Zero_i;
    end
  end

  // Read ports: x0 reads zero; a pending write to the same index wins over
  // the array contents because it is the newer value.
  always_comb begin
    Read_Data_1_o = regs[Read_Register_1_i];
    if (Read_Register_1_i == '0) begin
      Read_Data_1_o = '0;
    end else if (Wb_Valid_o && (Wb_Register_o == Read_Register_1_i)) begin
      Read_Data_1_o = wb_data;
    end
  end

  always_comb begin
    Read_Data_2_o = regs[Read_Register_2_i];
    if (Read_Register_2_i == '0) begin
      Read_Data_2_o = '0;
    end else if (Wb_Valid_o && (Wb_Register_o == Read_Register_2_i)) begin
      Read_Data_2_o = wb_data;
    end
  end

endmodule

// File: tb/tb_alu_writeback_regfile.sv
// ---------------------------------------------------------------------------
// tb_alu_writeback_regfile
//
// Scoreboard bench: the driver pushes the expected outputs for each cycle
// into a queue, and an independent monitor pops and compares them on the
// falling edge. Expected values come from a plain array model of the
// register file plus a one-entry pending-write record.
// ---------------------------------------------------------------------------
module tb_alu_writeback_regfile;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam logic [31:0] SP = 32'h7FFF_EFFC;
  localparam logic [31:0] GP = 32'h1000_8000;

  logic          clk = 1'b0;
  logic          reset;
  logic          Reg_Write_i;
  logic [AW-1:0] Write_Register_i;
  logic [DW-1:0] ALU_Result_i;
  logic          Zero_i;
  logic          Stall_i;
  logic          Flush_i;
  logic [AW-1:0] Read_Register_1_i;
  logic [AW-1:0] Read_Register_2_i;
  logic [DW-1:0] Read_Data_1_o;
  logic [DW-1:0] Read_Data_2_o;
  logic          Wb_Valid_o;
  logic [AW-1:0] Wb_Register_o;
  logic          Zero_q_o;

  alu_writeback_regfile #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SP_INIT(SP), .GP_INIT(GP)
  ) dut (
    .clk(clk), .reset(reset),
    .Reg_Write_i(Reg_Write_i), .Write_Register_i(Write_Register_i),
    .ALU_Result_i(ALU_Result_i), .Zero_i(Zero_i),
    .Stall_i(Stall_i), .Flush_i(Flush_i),
    .Read_Register_1_i(Read_Register_1_i), .Read_Register_2_i(Read_Register_2_i),
    .Read_Data_1_o(Read_Data_1_o), .Read_Data_2_o(Read_Data_2_o),
    .Wb_Valid_o(Wb_Valid_o), .Wb_Register_o(Wb_Register_o), .Zero_q_o(Zero_q_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] rd1;
    logic [DW-1:0] rd2;
    logic          valid;
    logic [AW-1:0] wreg;
    logic          zq;
    string         tag;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;

  // Reference model state.
  logic [DW-1:0] mem [32];
  logic          p_valid;
  logic [AW-1:0] p_reg;
  logic [DW-1:0] p_data;
  logic          m_zq;

  function automatic void model_reset();
    for (int i = 0; i < 32; i++) mem[i] = '0;
    mem[2] = SP;
    mem[3] = GP;
    p_valid = 1'b0; p_reg = '0; p_data = '0; m_zq = 1'b0;
  endfunction

  function automatic logic [DW-1:0] model_read(input logic [AW-1:0] idx);
    if (idx == 0) return '0;
    if (p_valid && p_reg == idx) return p_data;
    return mem[idx];
  endfunction

  // What one rising edge does to the model, given the inputs in force.
  function automatic void model_edge(input logic rst, input logic we, input logic [AW-1:0] wr,
                                     input logic [DW-1:0] res, input logic z,
                                     input logic st, input logic fl);
    if (rst) begin
      model_reset();
    end else if (!st) begin
      if (p_valid && p_reg != 0) mem[p_reg] = p_data;
      p_valid = we && !fl;
      p_reg   = wr;
      p_data  = res;
      m_zq    = z;
    end
  endfunction

  function automatic void compare(input string name, input logic [DW-1:0] act,
                                  input logic [DW-1:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, req);
    end
  endfunction

  // Drive one cycle: expected outputs for the current model state and read
  // indices are queued, then the edge is taken and the model advanced.
  task automatic applyStimulus(input string tag, input logic rst, input logic we,
                               input logic [AW-1:0] wr, input logic [DW-1:0] res,
                               input logic z, input logic st, input logic fl,
                               input logic [AW-1:0] ra1, input logic [AW-1:0] ra2);
    exp_t e;
    reset = rst; Reg_Write_i = we; Write_Register_i = wr; ALU_Result_i = res;
    Zero_i = z; Stall_i = st; Flush_i = fl;
    Read_Register_1_i = ra1; Read_Register_2_i = ra2;
    e.rd1 = model_read(ra1);
    e.rd2 = model_read(ra2);
    e.valid = p_valid;
    e.wreg = p_reg;
    e.zq = m_zq;
    e.tag = tag;
    exp_q.push_back(e);
    @(posedge clk);
    model_edge(rst, we, wr, res, z, st, fl);
    #1;
  endtask

  // Idle cycle that only observes two read ports.
  task automatic peek(input string tag, input logic [AW-1:0] ra1, input logic [AW-1:0] ra2);
    applyStimulus(tag, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0, ra1, ra2);
  endtask

  // Monitor: compares the DUT outputs against the oldest queued expectation.
  task automatic checkOutput();
    exp_t e;
    e = exp_q.pop_front();
    compare({e.tag, ".rd1"}, Read_Data_1_o, e.rd1);
    compare({e.tag, ".rd2"}, Read_Data_2_o, e.rd2);
    compare({e.tag, ".wb_valid"}, {31'b0, Wb_Valid_o}, {31'b0, e.valid});
    if (e.valid) compare({e.tag, ".wb_reg"}, {27'b0, Wb_Register_o}, {27'b0, e.wreg});
    compare({e.tag, ".zero_q"}, {31'b0, Zero_q_o}, {31'b0, e.zq});
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) checkOutput();
    end
  end

  initial begin
    // Initial reset edge brings DUT and model to a known state.
    reset = 1'b1; Reg_Write_i = 0; Write_Register_i = 0; ALU_Result_i = 0;
    Zero_i = 0; Stall_i = 0; Flush_i = 0; Read_Register_1_i = 0; Read_Register_2_i = 0;
    @(posedge clk);
    model_reset();
    #1;

    // Reset values.
    peek("rst_x0_x2", 5'd0, 5'd2);
    peek("rst_x3_x5", 5'd3, 5'd5);

    // Simple write to x5: bypass after first edge, array after second.
    applyStimulus("wr5", 0, 1, 5'd5, 32'hDEAD_BEEF, 0, 0, 0, 5'd5, 5'd5);
    peek("wr5_bypass", 5'd5, 5'd5);
    peek("wr5_array", 5'd5, 5'd0);

    // Write to x0 is discarded.
    applyStimulus("wr0", 0, 1, 5'd0, 32'h1234, 0, 0, 0, 5'd0, 5'd0);
    peek("wr0_a", 5'd0, 5'd0);
    peek("wr0_b", 5'd0, 5'd5);

    // Stall with a flushed x7 write held behind it.
    applyStimulus("cap7", 0, 1, 5'd7, 32'h55, 0, 0, 0, 5'd7, 5'd7);
    for (int i = 0; i < 3; i++)
      applyStimulus("stall7", 0, 1, 5'd7, 32'hAA, 0, 1, 1, 5'd7, 5'd7);
    applyStimulus("release7", 0, 1, 5'd7, 32'hAA, 0, 0, 1, 5'd7, 5'd7);
    peek("after7", 5'd7, 5'd7);

    // Flushed write never lands.
    applyStimulus("flush9", 0, 1, 5'd9, 32'h99, 0, 0, 1, 5'd9, 5'd9);
    peek("flush9_a", 5'd9, 5'd9);
    peek("flush9_b", 5'd9, 5'd9);

    // Back-to-back dependent writes to x4.
    for (int v = 1; v <= 3; v++)
      applyStimulus("b2b4", 0, 1, 5'd4, v, 0, 0, 0, 5'd4, 5'd4);
    peek("b2b4_last", 5'd4, 5'd4);
    peek("b2b4_final", 5'd4, 5'd4);

    // Reset while a write is pending.
    applyStimulus("pend4", 0, 1, 5'd4, 32'hCAFE, 0, 0, 0, 5'd4, 5'd4);
    applyStimulus("rst_pend", 1, 0, 5'd0, 32'h0, 0, 0, 0, 5'd4, 5'd4);
    peek("rst_pend_after", 5'd4, 5'd2);

    // Zero flag capture.
    applyStimulus("zero", 0, 1, 5'd6, 32'h0, 1, 0, 0, 5'd6, 5'd6);
    peek("zero_q", 5'd6, 5'd6);

    // Randomized traffic, indices biased toward a small set to hit bypasses.
    for (int n = 0; n < 400; n++) begin
      logic [AW-1:0] wr, a1, a2;
      logic [DW-1:0] res;
      wr  = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7));
      a1  = AW'($urandom_range(0, 7));
      a2  = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7));
      res = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom;
      applyStimulus("rand", $urandom_range(0, 49) == 0, $urandom_range(0, 3) != 0, wr, res,
                    res == 0, $urandom_range(0, 4) == 0, $urandom_range(0, 9) == 0, a1, a2);
    end

    // Let the monitor drain the last expectations.
    for (int t = 0; t < 10 && exp_q.size() > 0; t++) @(negedge clk);
    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      failures++;
      $display("[TB] FAIL drain actual=%0d pending required=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_writeback_regfile.md
Name: alu_writeback_regfile

Overview:
- Operand source and result sink for the 32-bit ALU.
- Holds the 32x32 integer register file and drives the ALU A/B operands from two read ports.
- Captures ALU_Result/Zero into a one-entry writeback register, then commits the result to the array on the following edge.
- Bypasses the pending writeback to the read ports so back-to-back dependent ALU ops see fresh data.

Parameters:
DATA_WIDTH, 32, register and ALU data width
ADDR_WIDTH, 5, register index width (2**ADDR_WIDTH registers)
SP_INIT, 32'h7FFF_EFFC, reset value of x2
GP_INIT, 32'h1000_8000, reset value of x3

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
Reg_Write_i  input  1  current ALU result is to be written back
Write_Register_i  input  ADDR_WIDTH  destination index for current ALU result
ALU_Result_i  input  DATA_WIDTH  ALU_Result_o of the ALU
Zero_i  input  1  Zero_o of the ALU
Stall_i  input  1  freeze writeback stage
Flush_i  input  1  discard current ALU result (capture as invalid)
Read_Register_1_i  input  ADDR_WIDTH  index for port 1 (ALU A_i)
Read_Register_2_i  input  ADDR_WIDTH  index for port 2 (ALU B_i)
Read_Data_1_o  output  DATA_WIDTH  port 1 data, combinational
Read_Data_2_o  output  DATA_WIDTH  port 2 data, combinational
Wb_Valid_o  output  1  writeback register holds a pending write
Wb_Register_o  output  ADDR_WIDTH  pending destination index
Zero_q_o  output  1  registered Zero of last captured result

Behaviour:
- One clock (clk); reset is synchronous and active-high.
- Reset (sampled at rising edge, overrides all else):
  - all registers = 0, except x2 = SP_INIT and x3 = GP_INIT
  - Wb_Valid_o = 0, Wb_Register_o = 0, internal wb_data = 0, Zero_q_o = 0
- Writeback stage, evaluated each edge when not in reset:
  - Commit: if Wb_Valid_o=1, Stall_i=0 and Wb_Register_o!=0, then reg[Wb_Register_o] <= wb_data.
  - Capture: if Stall_i=0:
    - Wb_Valid_o <= Reg_Write_i & ~Flush_i
    - Wb_Register_o <= Write_Register_i
    - wb_data <= ALU_Result_i
    - Zero_q_o <= Zero_i
  - Stall_i=1: the writeback register, Zero_q_o and the array all hold. The pending write is deferred to the first edge with Stall_i=0. Flush_i is ignored while stalled.
- Latency: a result present at edge N is captured at N and committed to the array at edge N+1 (absent stall).
  - Between N and N+1 its value is visible only through the bypass.
- Read ports are combinational. For port k:
  - index 0 -> 0 (x0 hardwired; writes to x0 are discarded, Wb_Valid_o may still be 1)
  - else if Wb_Valid_o=1 and Wb_Register_o==index -> wb_data (bypass, also during stall)
  - else reg[index]
- Both ports may read the same index; both get identical data.
- Capture and commit on the same edge is normal pipelining: the old entry commits while the new one is captured.
- Reset mid-stall: the pending write is lost and the array is reinitialised.
- No other state; no X on outputs after the first reset edge.

Test Plan:
- Reset, then read x0, x2, x3, x5 -> 0, 32'h7FFF_EFFC, 32'h1000_8000, 0; Wb_Valid_o=0, Zero_q_o=0.
- Reg_Write_i=1, rd=5, ALU_Result_i=32'hDEAD_BEEF for one cycle, read x5:
  - after edge 1: 32'hDEAD_BEEF via bypass, Wb_Valid_o=1
  - after edge 2 (Reg_Write_i=0): same value from array, Wb_Valid_o=0
- Write rd=0 value 32'h1234 -> read x0 returns 0 at every cycle; reg array unchanged.
- Capture rd=7 value 32'h55; hold Stall_i=1 for 3 cycles while presenting rd=7 value 32'hAA with Flush_i=1:
  - x7 reads 32'h55 (bypass) throughout
  - after release, x7=32'h55 committed; Flush_i applies only on the release edge
- Flush_i=1 with Reg_Write_i=1, rd=9, value 32'h99 -> Wb_Valid_o=0 next cycle; x9 stays 0.
- Back-to-back writes rd=4 values 1, 2, 3 on consecutive cycles, reading x4 each cycle -> 1, 2, 3 (bypass), final array x4=3.
- Assert reset while Wb_Valid_o=1, rd=4 -> x4=0, Wb_Valid_o=0.
- Zero_i=1 with result 0 -> Zero_q_o=1 one cycle later.
